// File: rtl/controle_multiciclo_pkg.sv
// -----------------------------------------------------------------------------
// controle_multiciclo_pkg
// Shared definitions for the multi-cycle RISC-V control unit:
//   - RV32I opcode constants handled by the controller
//   - 4-bit ALU control codes driven towards the ALU
//   - FSM state encoding (also exported on the debug 'state' port)
//   - bit index of funct7 that selects SUB over ADD for R-type
//   - helpers that classify opcodes and R-type funct3 values
// -----------------------------------------------------------------------------
package controle_multiciclo_pkg;

    // Opcodes (instruction[6:0])
    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    // ALU control codes
    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_ADDI = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;

    // funct7 bit that turns an R-type ADD into SUB
    localparam int SUB_BIT = 5;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_ERROR     = 3'd5,
        ST_TRAP      = 3'd6
    } state_t;

    // True for the opcodes the controller sequences through EXECUTE.
    function automatic logic opcode_known(input logic [6:0] op);
        return (op == OP_LW) || (op == OP_SW) || (op == OP_ADDI) ||
               (op == OP_RTYPE) || (op == OP_BEQ);
    endfunction

    // R-type funct3 values that map onto a real ALU operation.
    function automatic logic rtype_funct_legal(input logic [2:0] f3);
        return !(f3 inside {3'b001, 3'b010, 3'b011});
    endfunction

endpackage

// File: rtl/controle_multiciclo_alu_decoder.sv
// -----------------------------------------------------------------------------
// alu_decoder
// Purely combinational ALU operation decoder working on the instruction
// fields latched in DECODE.
// Ports:
//   opcode_i     [6:0]            latched opcode
//   funct3_i     [2:0]            latched funct3
//   funct7_i     [6:0]            latched funct7 (only the SUB bit matters)
//   alucontrol_o [ALUCTRL_W-1:0]  ALU operation, upper bits zero-filled
//   alusrc_o                      operand B select: 0 register, 1 immediate
// -----------------------------------------------------------------------------
module alu_decoder
    import controle_multiciclo_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic [6:0]           opcode_i,
    input  logic [2:0]           funct3_i,
    input  logic [6:0]           funct7_i,
    output logic [ALUCTRL_W-1:0] alucontrol_o,
    output logic                 alusrc_o
);

    logic [3:0] alu_op;

    // Only funct7[SUB_BIT] distinguishes operations in the supported subset.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7_i[6:SUB_BIT+1], funct7_i[SUB_BIT-1:0]};

    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    always_comb begin
        alu_op   = ALU_ADD;
        alusrc_o = 1'b0;
        unique case (opcode_i)
            OP_LW, OP_SW: begin
                alu_op   = ALU_ADD;
                alusrc_o = 1'b1;
            end
            OP_ADDI: begin
                alu_op   = ALU_ADDI;
                alusrc_o = 1'b1;
            end
            OP_RTYPE: begin
                case (funct3_i)
                    3'b000:  alu_op = funct7_i[SUB_BIT] ? ALU_SUB : ALU_ADD;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    3'b111:  alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            OP_BEQ:  alu_op = ALU_SUB;
            default: alu_op = ALU_ADD;
        endcase
    end

    assign alucontrol_o = ALUCTRL_W'(alu_op);

endmodule

// File: rtl/controle_multiciclo.sv
// -----------------------------------------------------------------------------
// controle_multiciclo
// Multi-cycle control FSM for the RISC-V datapath. Sequences
// FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK, waits on a memory ready handshake
// with a timeout that parks the FSM in ERROR, and resolves beq from the
// ALU zero flag.
//
// Optional feature: define ILLEGAL_TRAP_EN to send unlisted opcodes and
// unlisted R-type funct3 values to the TRAP state (left only by reset)
// instead of retiring them as NOPs.
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   opcode/funct3/funct7  instruction fields from IR, sampled in DECODE
//   zero               ALU zero flag, used by beq in EXECUTE
//   mem_ready          memory finished the current access
//   ir_write, pc_write, pc_src   IR load, PC update, PC source select
//   regiwrite, memread, memwrite, memtoreg, alusrc, alucontrol
//                      datapath controls for the current state
//   instr_done         pulse on the last cycle of each instruction
//   bus_error          sticky memory timeout flag
//   state              current FSM state (debug)
// -----------------------------------------------------------------------------
module controle_multiciclo
    import controle_multiciclo_pkg::*;
#(
    parameter int ALUCTRL_W   = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           opcode,
    input  logic [2:0]           funct3,
    input  logic [6:0]           funct7,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 regiwrite,
    output logic                 memread,
    output logic                 memwrite,
    output logic                 memtoreg,
    output logic                 alusrc,
    output logic [ALUCTRL_W-1:0] alucontrol,
    output logic                 instr_done,
    output logic                 bus_error,
    output logic [2:0]           state
);

    // The timeout fires on the MEM_TIMEOUT-th consecutive waiting cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);
    localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

    state_t          state_q;
    logic [TO_W-1:0] to_cnt_q;
    logic [6:0]      opcode_q;
    logic [2:0]      funct3_q;
    logic [6:0]      funct7_q;
    logic            bus_error_q;

    logic                 to_hit;
    logic                 decode_legal;
    logic [ALUCTRL_W-1:0] dec_alucontrol;
    logic                 dec_alusrc;

    assign to_hit = (MEM_TIMEOUT != 0) && (to_cnt_q == TO_LAST);

`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
    assign decode_legal = opcode_known(opcode) &&
                          ((opcode != OP_RTYPE) || rtype_funct_legal(funct3));
`else
    localparam bit TRAP_EN = 1'b0;
    assign decode_legal = opcode_known(opcode);
`endif

    alu_decoder #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_alu_decoder (
        .opcode_i     (opcode_q),
        .funct3_i     (funct3_q),
        .funct7_i     (funct7_q),
        .alucontrol_o (dec_alucontrol),
        .alusrc_o     (dec_alusrc)
    );

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_FETCH;
            to_cnt_q    <= '0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            bus_error_q <= 1'b0;
        end else begin
            case (state_q)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state_q  <= ST_DECODE;
                        to_cnt_q <= '0;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_ONE;
                        if (to_hit) begin
                            state_q     <= ST_ERROR;
                            bus_error_q <= 1'b1;
                        end
                    end
                end
                ST_DECODE: begin
                    opcode_q <= opcode;
                    funct3_q <= funct3;
                    funct7_q <= funct7;
                    to_cnt_q <= '0;
                    if (decode_legal)
                        state_q <= ST_EXECUTE;
                    else
                        state_q <= TRAP_EN ? ST_TRAP : ST_FETCH;
                end
                ST_EXECUTE: begin
                    // Clearing here guarantees MEMORY starts with a fresh count.
                    to_cnt_q <= '0;
                    case (opcode_q)
                        OP_LW, OP_SW:      state_q <= ST_MEMORY;
                        OP_ADDI, OP_RTYPE: state_q <= ST_WRITEBACK;
                        default:           state_q <= ST_FETCH;
                    endcase
                end
                ST_MEMORY: begin
                    if (mem_ready) begin
                        to_cnt_q <= '0;
                        state_q  <= (opcode_q == OP_LW) ? ST_WRITEBACK : ST_FETCH;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_ONE;
                        if (to_hit) begin
                            state_q     <= ST_ERROR;
                            bus_error_q <= 1'b1;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    to_cnt_q <= '0;
                    state_q  <= ST_FETCH;
                end
                ST_ERROR, ST_TRAP: state_q <= state_q;
                default:           state_q <= ST_FETCH;
            endcase
        end
    end

    // Controls decode from the state register and latched fields; FETCH,
    // DECODE (NOP retire), EXECUTE (beq) and MEMORY also look at the live
    // handshake/flag inputs. Gating with rst_n forces every control low
    // while reset is held, so an aborted store cannot complete.
    always_comb begin
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        regiwrite  = 1'b0;
        memread    = 1'b0;
        memwrite   = 1'b0;
        memtoreg   = 1'b0;
        alusrc     = 1'b0;
        alucontrol = '0;
        instr_done = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    memread = 1'b1;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                    end
                end
                ST_DECODE: begin
                    instr_done = !decode_legal && !TRAP_EN;
                end
                ST_EXECUTE: begin
                    alucontrol = dec_alucontrol;
                    alusrc     = dec_alusrc;
                    if (opcode_q == OP_BEQ) begin
                        pc_write   = zero;
                        pc_src     = 1'b1;
                        instr_done = 1'b1;
                    end
                end
                ST_MEMORY: begin
                    memread    = (opcode_q == OP_LW);
                    memwrite   = (opcode_q == OP_SW);
                    instr_done = mem_ready && (opcode_q == OP_SW);
                end
                ST_WRITEBACK: begin
                    regiwrite  = 1'b1;
                    memtoreg   = (opcode_q == OP_LW);
                    alucontrol = dec_alucontrol;
                    alusrc     = dec_alusrc;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus_error = bus_error_q;
    assign state     = state_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_controle_multiciclo
// Directed self-checking bench for controle_multiciclo with default
// parameters (ALUCTRL_W=4, MEM_TIMEOUT=15). Inputs change on the falling
// edge; outputs are compared 1 ns after it as one packed control word:
// {ir_write,pc_write,pc_src,regiwrite,memread,memwrite,memtoreg,alusrc,
//  alucontrol[3:0],instr_done,bus_error,state[2:0]}
// -----------------------------------------------------------------------------
module tb_controle_multiciclo;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       zero;
    logic       mem_ready;
    logic       ir_write, pc_write, pc_src, regiwrite, memread, memwrite;
    logic       memtoreg, alusrc, instr_done, bus_error;
    logic [3:0] alucontrol;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    logic [16:0] obs;
    assign obs = {ir_write, pc_write, pc_src, regiwrite, memread, memwrite,
                  memtoreg, alusrc, alucontrol, instr_done, bus_error, state};

    controle_multiciclo #(
        .ALUCTRL_W   (4),
        .MEM_TIMEOUT (15),
        .TO_W        (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .regiwrite  (regiwrite),
        .memread    (memread),
        .memwrite   (memwrite),
        .memtoreg   (memtoreg),
        .alusrc     (alusrc),
        .alucontrol (alucontrol),
        .instr_done (instr_done),
        .bus_error  (bus_error),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [16:0] ctl(
        input logic ir, pcw, pcs, rw, mr, mw, mtr, asrc,
        input logic [3:0] alu,
        input logic done, berr,
        input logic [2:0] st
    );
        return {ir, pcw, pcs, rw, mr, mw, mtr, asrc, alu, done, berr, st};
    endfunction

    task automatic check(input string tag, input logic [16:0] got, input logic [16:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Advance to the next falling edge and let outputs settle.
    task automatic nxt();
        @(negedge clk);
        #1;
    endtask

    // Assert reset mid-cycle, confirm all outputs are low, release on a
    // falling edge. Returns 1 ns into the first FETCH cycle.
    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        #1;
        check(tag, obs, 17'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // One ALU instruction from FETCH through WRITEBACK. Opcode inputs are
    // scrambled after DECODE to show that only latched fields matter.
    task automatic alu_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic [6:0] f7, input logic [3:0] alu, input logic src);
        opcode = op; funct3 = f3; funct7 = f7;
        nxt();
        check({tag, ".dec"}, obs, ctl(0,0,0,0,0,0,0,0,4'h0,0,0,3'd1));
        nxt();
        opcode = 7'h7f; funct3 = ~f3; funct7 = ~f7;
        #1;
        check({tag, ".exec"}, obs, ctl(0,0,0,0,0,0,0,src,alu,0,0,3'd2));
        nxt();
        check({tag, ".wb"}, obs, ctl(0,0,0,1,0,0,0,src,alu,1,0,3'd4));
        nxt();
    endtask

    initial begin
        opcode = '0; funct3 = '0; funct7 = '0; zero = 1'b0; mem_ready = 1'b1; rst_n = 1'b0;
        do_reset("reset");

        // add x3,x1,x2: states 0,1,2,4
        opcode = OP_RTYPE; funct3 = 3'b000; funct7 = 7'b0000000;
        check("add.fetch", obs, ctl(1,1,0,0,1,0,0,0,4'h0,0,0,3'd0));
        nxt(); check("add.dec",   obs, ctl(0,0,0,0,0,0,0,0,4'h0,0,0,3'd1));
        nxt(); check("add.exec",  obs, ctl(0,0,0,0,0,0,0,0,4'b0010,0,0,3'd2));
        nxt(); check("add.wb",    obs, ctl(0,0,0,1,0,0,0,0,4'b0010,1,0,3'd4));
        nxt(); check("add.fetch2", obs, ctl(1,1,0,0,1,0,0,0,4'h0,0,0,3'd0));

        alu_instr("sub",  OP_RTYPE, 3'b000, 7'b0100000, 4'b0110, 1'b0);
        alu_instr("xor",  OP_RTYPE, 3'b100, 7'b0000000, 4'b0100, 1'b0);
        alu_instr("srl",  OP_RTYPE, 3'b101, 7'b0100000, 4'b0101, 1'b0);
        alu_instr("or",   OP_RTYPE, 3'b110, 7'b0000000, 4'b0001, 1'b0);
        alu_instr("and",  OP_RTYPE, 3'b111, 7'b0000000, 4'b0000, 1'b0);
`ifndef ILLEGAL_TRAP_EN
        alu_instr("r001", OP_RTYPE, 3'b001, 7'b0000000, 4'b0010, 1'b0);
`endif
        alu_instr("addi", OP_ADDI,  3'b000, 7'b0000000, 4'b0011, 1'b1);

        // lw with mem_ready arriving on the 4th MEMORY cycle: 8 cycles total
        opcode = OP_LW; funct3 = 3'b010; funct7 = '0;
        check("lw.fetch", obs, ctl(1,1,0,0,1,0,0,0,4'h0,0,0,3'd0));
        nxt(); check("lw.dec", obs, ctl(0,0,0,0,0,0,0,0,4'h0,0,0,3'd1));
        nxt(); mem_ready = 1'b0; #1;
        check("lw.exec", obs, ctl(0,0,0,0,0,0,0,1,4'b0010,0,0,3'd2));
        for (int i = 0; i < 3; i++) begin
            nxt(); check("lw.mem_wait", obs, ctl(0,0,0,0,1,0,0,0,4'h0,0,0,3'd3));
        end
        nxt(); mem_ready = 1'b1; #1;
        check("lw.mem_rdy", obs, ctl(0,0,0,0,1,0,0,0,4'h0,0,0,3'd3));
        nxt(); check("lw.wb", obs, ctl(0,0,0,1,0,0,1,1,4'b0010,1,0,3'd4));
        nxt(); check("lw.fetch2", obs, ctl(1,1,0,0,1,0,0,0,4'h0,0,0,3'd0));

        // sw with immediate ready: done in MEMORY
        opcode = OP_SW;
        nxt(); nxt();
        check("sw.exec", obs, ctl(0,0,0,0,0,0,0,1,4'b0010,0,0,3'd2));
        nxt(); check("sw.mem", obs, ctl(0,0,0,0,0,1,0,0,4'h0,1,0,3'd3));
        nxt(); check("sw.fetch2", obs, ctl(1,1,0,0,1,0,0,0,4'h0,0,0,3'd0));

        // beq taken then not taken
        opcode = OP_BEQ;
        nxt(); nxt(); zero = 1'b1; #1;
        check("beq1.exec", obs, ctl(0,1,1,0,0,0,0,0,4'b0110,1,0,3'd2));
        nxt(); check("beq1.fetch", obs, ctl(1,1,0,0,1,0,0,0,4'h0,0,0,3'd0));
        nxt(); nxt(); zero = 1'b0; #1;
        check("beq0.exec", obs, ctl(0,0,1,0,0,0,0,0,4'b0110,1,0,3'd2));
        nxt(); check("beq0.fetch", obs, ctl(1,1,0,0,1,0,0,0,4'h0,0,0,3'd0));

        // reset during MEMORY of sw aborts the store immediately
        opcode = OP_SW;
        nxt(); nxt(); mem_ready = 1'b0;
        nxt(); check("swab.mem", obs, ctl(0,0,0,0,0,1,0,0,4'h0,0,0,3'd3));
        do_reset("swab.rst");
        check("swab.post", obs, ctl(0,0,0,0,1,0,0,0,4'h0,0,0,3'd0));

        // ready on the last allowed cycle beats the timeout
        repeat (13) nxt();
        check("race.wait14", obs, ctl(0,0,0,0,1,0,0,0,4'h0,0,0,3'd0));
        nxt(); mem_ready = 1'b1; opcode = 7'b1111111; #1;
        check("race.rdy15", obs, ctl(1,1,0,0,1,0,0,0,4'h0,0,0,3'd0));
        nxt();
`ifdef ILLEGAL_TRAP_EN
        check("ill.dec", obs, ctl(0,0,0,0,0,0,0,0,4'h0,0,0,3'd1));
        nxt(); check("ill.trap", obs, ctl(0,0,0,0,0,0,0,0,4'h0,0,0,3'd6));
        repeat (3) nxt();
        check("ill.hold", obs, ctl(0,0,0,0,0,0,0,0,4'h0,0,0,3'd6));
`else
        check("nop.dec", obs, ctl(0,0,0,0,0,0,0,0,4'h0,1,0,3'd1));
        nxt(); check("nop.fetch", obs, ctl(1,1,0,0,1,0,0,0,4'h0,0,0,3'd0));
`endif
        do_reset("pre_to.rst");

        // FETCH timeout: ERROR after 15 waiting cycles, sticky until reset
        mem_ready = 1'b0; #1;
        check("to.wait1", obs, ctl(0,0,0,0,1,0,0,0,4'h0,0,0,3'd0));
        repeat (14) nxt();
        check("to.wait15", obs, ctl(0,0,0,0,1,0,0,0,4'h0,0,0,3'd0));
        nxt(); check("to.error", obs, ctl(0,0,0,0,0,0,0,0,4'h0,0,1,3'd5));
        mem_ready = 1'b1;
        repeat (3) nxt();
        check("to.sticky", obs, ctl(0,0,0,0,0,0,0,0,4'h0,0,1,3'd5));
        do_reset("to.rst");
        check("to.cleared", obs, ctl(1,1,0,0,1,0,0,0,4'h0,0,0,3'd0));

        // MEMORY timeout on lw
        opcode = OP_LW;
        nxt(); nxt(); mem_ready = 1'b0;
        nxt();
        repeat (14) nxt();
        check("mto.wait15", obs, ctl(0,0,0,0,1,0,0,0,4'h0,0,0,3'd3));
        nxt(); check("mto.error", obs, ctl(0,0,0,0,0,0,0,0,4'h0,0,1,3'd5));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
